// File: rtl/tdm_serializer.sv
// Multi-channel parallel-in/serial-out TDM serializer: one frame per handshake, double-buffered
// behind the active shift register, one bit per enable strobe with frame-sync and sticky underrun.
module tdm_serializer #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int MSB_FIRST  = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      enable,
  input  logic                      clr_underrun,
  output logic                      sdata,
  output logic                      fsync,
  output logic                      underrun
);

  localparam int FRAME_BITS = CHANNELS * SLOT_WIDTH;
  localparam int CNT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    r_state;
  logic [CHANNELS*WIDTH-1:0] r_hold_data;
  logic                      r_hold_full;
  logic [FRAME_BITS-1:0]     r_shift;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_underrun;
  logic                      r_sdata;
  logic                      r_fsync;

  logic                      w_handshake;
  logic                      w_boundary;
  logic                      w_consume;
  logic [FRAME_BITS-1:0]     w_load_frame;
  logic [FRAME_BITS-1:0]     w_shift_next;

  // Top bit of the frame vector is the first bit on the wire; padding stays zero.
  function automatic logic [FRAME_BITS-1:0] format_frame(input logic [CHANNELS*WIDTH-1:0] d);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (MSB_FIRST != 0)
          f[FRAME_BITS-1-(c*SLOT_WIDTH+j)] = d[c*WIDTH+WIDTH-1-j];
        else
          f[FRAME_BITS-1-(c*SLOT_WIDTH+j)] = d[c*WIDTH+j];
      end
    end
    return f;
  endfunction

  assign w_handshake  = in_valid && !r_hold_full;
  assign w_boundary   = (r_state == RUN) && enable && (r_cnt == LAST_BIT);
  assign w_consume    = enable && r_hold_full && ((r_state == IDLE) || (r_cnt == LAST_BIT));
  assign w_load_frame = r_hold_full ? format_frame(r_hold_data) : '0;
  assign w_shift_next = r_shift << 1;

  assign in_ready = !r_hold_full;
  assign sdata    = r_sdata;
  assign fsync    = r_fsync;
  assign underrun = r_underrun;

  always_ff @(posedge clk) begin
    if (w_handshake)
      r_hold_data <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_underrun  <= 1'b0;
      r_sdata     <= 1'b0;
      r_fsync     <= 1'b0;
    end else begin
      // A handshake needs an empty buffer and a drain needs a full one, so they never collide.
      if (w_handshake)
        r_hold_full <= 1'b1;
      else if (w_consume)
        r_hold_full <= 1'b0;

      if (w_boundary && !r_hold_full)
        r_underrun <= 1'b1;
      else if (clr_underrun)
        r_underrun <= 1'b0;

      if (enable) begin
        case (r_state)
          IDLE: begin
            if (r_hold_full) begin
              r_shift <= w_load_frame;
              r_sdata <= w_load_frame[FRAME_BITS-1];
              r_fsync <= 1'b1;
              r_cnt   <= '0;
              r_state <= RUN;
            end
          end
          RUN: begin
            if (r_cnt == LAST_BIT) begin
              r_shift <= w_load_frame;
              r_sdata <= w_load_frame[FRAME_BITS-1];
              r_fsync <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_shift <= w_shift_next;
              r_sdata <= w_shift_next[FRAME_BITS-1];
              r_fsync <= 1'b0;
              r_cnt   <= r_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_serializer.sv
// Randomized self-checking bench for tdm_serializer against a frame/bit-position reference model.
module tb_tdm_serializer;

  localparam int CH = 2;
  localparam int W  = 24;
  localparam int SW = 32;
  localparam int FB = CH * SW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [CH*W-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          enable = 1'b0;
  logic          clr_underrun = 1'b0;
  logic          sdata, fsync, underrun;

  logic [CH*W-1:0] l_in_data = '0;
  logic          l_in_valid = 1'b0;
  logic          l_in_ready;
  logic          l_enable = 1'b0;
  logic          l_clr = 1'b0;
  logic          l_sdata, l_fsync, l_underrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: which frame is playing and which bit of it is on the wire.
  logic [CH*W-1:0] pending[$];
  bit              m_running;
  int              m_pos;
  logic [CH*W-1:0] m_cur;
  logic            m_underrun, m_sdata, m_fsync, m_ready, m_hs;

  tdm_serializer #(.CHANNELS(CH), .WIDTH(W), .SLOT_WIDTH(SW), .MSB_FIRST(1)) dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .enable(enable), .clr_underrun(clr_underrun), .sdata(sdata), .fsync(fsync), .underrun(underrun)
  );

  tdm_serializer #(.CHANNELS(CH), .WIDTH(W), .SLOT_WIDTH(SW), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rstn(rstn), .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .enable(l_enable), .clr_underrun(l_clr), .sdata(l_sdata), .fsync(l_fsync), .underrun(l_underrun)
  );

  always #5 clk = ~clk;

  function automatic logic exp_bit(input logic [CH*W-1:0] f, input int k, input bit msb);
    int slot, j;
    logic [W-1:0] s;
    slot = k / SW;
    j    = k % SW;
    if (j >= W) return 1'b0;
    s = f[slot*W +: W];
    return msb ? s[W-1-j] : s[j];
  endfunction

  function automatic logic [CH*W-1:0] rand_frame();
    logic [CH*W-1:0] r;
    r = {16'($urandom), $urandom};
    return r;
  endfunction

  // Drive one cycle, advance the reference model at the edge, and leave outputs ready to sample.
  task automatic cycle(input logic v, input logic [CH*W-1:0] d, input logic en, input logic clr);
    logic set_ur;
    in_valid = v; in_data = d; enable = en; clr_underrun = clr;
    m_hs = v && (pending.size() == 0) && rstn;
    set_ur = 1'b0;
    @(posedge clk);
    if (!rstn) begin
      m_running = 0; m_pos = 0; m_cur = '0; m_underrun = 1'b0;
      pending.delete();
    end else begin
      if (en) begin
        if (!m_running) begin
          if (pending.size() > 0) begin
            m_cur = pending.pop_front(); m_running = 1; m_pos = 0;
          end
        end else if (m_pos == FB - 1) begin
          m_pos = 0;
          if (pending.size() > 0) m_cur = pending.pop_front();
          else begin m_cur = '0; set_ur = 1'b1; end
        end else begin
          m_pos++;
        end
      end
      if (set_ur) m_underrun = 1'b1;
      else if (clr) m_underrun = 1'b0;
      if (m_hs) pending.push_back(d);
    end
    m_sdata = m_running ? exp_bit(m_cur, m_pos, 1'b1) : 1'b0;
    m_fsync = m_running && (m_pos == 0);
    m_ready = (pending.size() == 0);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cycle(1'b1, rand_frame(), 1'b1, 1'b0);
    cycle(1'b1, rand_frame(), 1'b1, 1'b0);
    rstn = 1'b1;
    n_checks++; if (sdata !== 1'b0) begin n_fail++; $display("FAIL reset_sdata got %b expected 0", sdata); end
    n_checks++; if (fsync !== 1'b0) begin n_fail++; $display("FAIL reset_fsync got %b expected 0", fsync); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got %b expected 0", underrun); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (sdata !== 1'b0 || fsync !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset sdata/fsync got %b%b expected 00", sdata, fsync); end
    n_checks++; if (underrun !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_enable underrun/in_ready got %b%b expected 01", underrun, in_ready); end
  endtask

  task automatic test_pattern();
    logic [63:0] lit;
    lit = 64'hA5A5A500_00000100;
    do_reset();
    cycle(1'b1, {24'h000001, 24'hA5A5A5}, 1'b0, 1'b0);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL pattern_hold_full in_ready got %b expected 0", in_ready); end
    for (int k = 0; k < FB; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (sdata !== lit[63-k]) begin n_fail++; $display("FAIL pattern_sdata bit %0d got %b expected %b", k, sdata, lit[63-k]); end
      n_checks++; if (sdata !== m_sdata) begin n_fail++; $display("FAIL pattern_model bit %0d got %b expected %b", k, sdata, m_sdata); end
      n_checks++; if (fsync !== (k == 0)) begin n_fail++; $display("FAIL pattern_fsync bit %0d got %b expected %b", k, fsync, (k == 0)); end
      n_checks++; if (in_ready !== m_ready) begin n_fail++; $display("FAIL pattern_in_ready bit %0d got %b expected %b", k, in_ready, m_ready); end
    end
  endtask

  task automatic test_back_to_back();
    logic [CH*W-1:0] fr[3];
    int acc[3];
    int sent;
    int exp_acc[3];
    exp_acc = '{0, 2, 66};
    do_reset();
    for (int i = 0; i < 3; i++) fr[i] = rand_frame();
    sent = 0;
    for (int i = 0; i < 3 * FB + 8; i++) begin
      cycle(sent < 3, fr[(sent < 3) ? sent : 0], 1'b1, 1'b0);
      if (m_hs) begin acc[sent] = i; sent++; end
      n_checks++; if (in_ready !== m_ready) begin n_fail++; $display("FAIL b2b_in_ready cyc %0d got %b expected %b", i, in_ready, m_ready); end
      n_checks++; if (sdata !== m_sdata || fsync !== m_fsync) begin n_fail++; $display("FAIL b2b_out cyc %0d sdata/fsync got %b%b expected %b%b", i, sdata, fsync, m_sdata, m_fsync); end
      if (i >= 1 && i <= 3 * FB) begin
        n_checks++;
        if (sdata !== exp_bit(fr[(i-1)/FB], (i-1) % FB, 1'b1)) begin
          n_fail++; $display("FAIL b2b_stream cyc %0d got %b expected %b", i, sdata, exp_bit(fr[(i-1)/FB], (i-1) % FB, 1'b1));
        end
      end
    end
    n_checks++; if (sent !== 3) begin n_fail++; $display("FAIL b2b_sent got %0d expected 3", sent); end
    for (int j = 0; j < 3; j++) begin
      n_checks++; if (acc[j] !== exp_acc[j]) begin n_fail++; $display("FAIL b2b_accept_cycle frame %0d got %0d expected %0d", j, acc[j], exp_acc[j]); end
    end
  endtask

  task automatic test_underrun();
    logic [CH*W-1:0] f2;
    int guard;
    do_reset();
    cycle(1'b1, rand_frame(), 1'b0, 1'b0);
    for (int i = 0; i < 2 * FB + 1; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (underrun !== m_underrun) begin n_fail++; $display("FAIL ur_flag cyc %0d got %b expected %b", i, underrun, m_underrun); end
      n_checks++; if (sdata !== m_sdata || fsync !== m_fsync) begin n_fail++; $display("FAIL ur_out cyc %0d sdata/fsync got %b%b expected %b%b", i, sdata, fsync, m_sdata, m_fsync); end
      if (i == FB) begin
        n_checks++; if (underrun !== 1'b1 || fsync !== 1'b1 || sdata !== 1'b0) begin n_fail++; $display("FAIL ur_zero_frame_start underrun/fsync/sdata got %b%b%b expected 110", underrun, fsync, sdata); end
      end
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_clear got %b expected 0", underrun); end
    guard = 0;
    while (m_pos != FB - 1 && guard < 2 * FB) begin cycle(1'b0, '0, 1'b1, 1'b0); guard++; end
    n_checks++; if (guard >= 2 * FB) begin n_fail++; $display("FAIL ur_wait_boundary got timeout expected boundary"); end
    f2 = rand_frame();
    cycle(1'b1, f2, 1'b1, 1'b1);
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_set_beats_clr got %b expected 1", underrun); end
    n_checks++; if (in_ready !== 1'b0 || fsync !== 1'b1 || sdata !== 1'b0) begin n_fail++; $display("FAIL ur_simul_hs in_ready/fsync/sdata got %b%b%b expected 010", in_ready, fsync, sdata); end
    for (int k = 1; k < 2 * FB; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (sdata !== m_sdata || fsync !== m_fsync) begin n_fail++; $display("FAIL ur_after cyc %0d sdata/fsync got %b%b expected %b%b", k, sdata, fsync, m_sdata, m_fsync); end
      if (k >= FB) begin
        n_checks++; if (sdata !== exp_bit(f2, k - FB, 1'b1)) begin n_fail++; $display("FAIL ur_late_frame bit %0d got %b expected %b", k - FB, sdata, exp_bit(f2, k - FB, 1'b1)); end
      end
    end
  endtask

  task automatic test_sparse_enable();
    logic [63:0] lit;
    int s;
    lit = 64'hA5A5A500_00000100;
    do_reset();
    cycle(1'b1, {24'h000001, 24'hA5A5A5}, 1'b0, 1'b0);
    s = 0;
    for (int i = 0; i < 4 * FB; i++) begin
      cycle(1'b0, '0, (i % 4) == 0, 1'b0);
      if ((i % 4) == 0) s++;
      n_checks++; if (sdata !== m_sdata || fsync !== m_fsync) begin n_fail++; $display("FAIL sparse_model cyc %0d sdata/fsync got %b%b expected %b%b", i, sdata, fsync, m_sdata, m_fsync); end
      n_checks++; if (sdata !== lit[64-s]) begin n_fail++; $display("FAIL sparse_bit strobe %0d got %b expected %b", s - 1, sdata, lit[64-s]); end
      n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL sparse_underrun cyc %0d got %b expected 0", i, underrun); end
    end
  endtask

  task automatic test_lsb_first();
    logic [CH*W-1:0] f1, f2;
    logic e;
    do_reset();
    f1 = {24'($urandom), 24'h000001};
    f2 = {24'($urandom), 24'h800000};
    l_in_data = f1; l_in_valid = 1'b1; l_enable = 1'b0;
    @(posedge clk); #1;
    l_in_data = f2; l_enable = 1'b1;
    for (int k = 0; k < 2 * FB; k++) begin
      l_in_valid = (k == 1);
      @(posedge clk); #1;
      e = (k < FB) ? exp_bit(f1, k, 1'b0) : exp_bit(f2, k - FB, 1'b0);
      n_checks++; if (l_sdata !== e) begin n_fail++; $display("FAIL lsb_sdata bit %0d got %b expected %b", k, l_sdata, e); end
      n_checks++; if (l_fsync !== ((k % FB) == 0)) begin n_fail++; $display("FAIL lsb_fsync bit %0d got %b expected %b", k, l_fsync, (k % FB) == 0); end
      if (k < SW) begin
        n_checks++; if (l_sdata !== (k == 0)) begin n_fail++; $display("FAIL lsb_one bit %0d got %b expected %b", k, l_sdata, k == 0); end
      end else if (k >= FB && k < FB + SW) begin
        n_checks++; if (l_sdata !== (k == FB + 23)) begin n_fail++; $display("FAIL lsb_msbval bit %0d got %b expected %b", k - FB, l_sdata, k == FB + 23); end
      end
    end
    l_in_valid = 1'b0; l_enable = 1'b0;
    n_checks++; if (l_underrun !== 1'b0) begin n_fail++; $display("FAIL lsb_underrun got %b expected 0", l_underrun); end
  endtask

  task automatic test_midframe_reset();
    logic [CH*W-1:0] f;
    int guard;
    do_reset();
    guard = 0;
    while (!(m_running && m_pos == 17 && pending.size() > 0) && guard < 200) begin
      cycle(1'b1, rand_frame(), 1'b1, 1'b0);
      guard++;
    end
    n_checks++; if (guard >= 200) begin n_fail++; $display("FAIL mid_reach_bit17 got timeout expected bit 17"); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_hold_full in_ready got %b expected 0", in_ready); end
    rstn = 1'b0;
    cycle(1'b1, rand_frame(), 1'b1, 1'b0);
    rstn = 1'b1;
    n_checks++; if (sdata !== 1'b0 || fsync !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out sdata/fsync got %b%b expected 00", sdata, fsync); end
    n_checks++; if (in_ready !== 1'b1 || underrun !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ctl in_ready/underrun got %b%b expected 10", in_ready, underrun); end
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (sdata !== 1'b0 || fsync !== 1'b0) begin n_fail++; $display("FAIL mid_discarded sdata/fsync got %b%b expected 00", sdata, fsync); end
    f = rand_frame();
    cycle(1'b1, f, 1'b0, 1'b0);
    for (int k = 0; k < FB; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (sdata !== exp_bit(f, k, 1'b1)) begin n_fail++; $display("FAIL mid_restart bit %0d got %b expected %b", k, sdata, exp_bit(f, k, 1'b1)); end
      n_checks++; if (fsync !== (k == 0)) begin n_fail++; $display("FAIL mid_restart_fsync bit %0d got %b expected %b", k, fsync, k == 0); end
    end
  endtask

  task automatic test_random_stream();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      cycle(1'($urandom % 2), rand_frame(), ($urandom % 10) < 7, ($urandom % 20) == 0);
      n_checks++; if (sdata !== m_sdata || fsync !== m_fsync) begin n_fail++; $display("FAIL rand_out cyc %0d sdata/fsync got %b%b expected %b%b", i, sdata, fsync, m_sdata, m_fsync); end
      n_checks++; if (underrun !== m_underrun) begin n_fail++; $display("FAIL rand_underrun cyc %0d got %b expected %b", i, underrun, m_underrun); end
      n_checks++; if (in_ready !== m_ready) begin n_fail++; $display("FAIL rand_in_ready cyc %0d got %b expected %b", i, in_ready, m_ready); end
    end
  endtask

  initial begin
    m_running = 0; m_pos = 0; m_cur = '0; m_underrun = 1'b0;
    m_sdata = 1'b0; m_fsync = 1'b0; m_ready = 1'b1; m_hs = 1'b0;
    test_reset();
    test_pattern();
    test_back_to_back();
    test_underrun();
    test_sparse_enable();
    test_lsb_first();
    test_midframe_reset();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
